// File: rtl/linear_layer_fifo_pkg.sv
// rtl/linear_layer_fifo_pkg.sv - shared sizing and parameter-legality helpers for Linear_Layer FIFOs
package linear_layer_fifo_pkg;

  function automatic int unsigned occ_width(input int unsigned depth, input int unsigned out_reg);
    return $clog2(depth + out_reg + 1);
  endfunction

  function automatic bit srl_params_ok(input int unsigned data_width, input int unsigned addr_width,
                                       input int unsigned depth, input int unsigned out_reg);
    return (data_width >= 1) && (depth >= 2) && (depth <= (1 << addr_width)) &&
           (out_reg <= 1) && (occ_width(depth, out_reg) <= addr_width + 1);
  endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_shiftreg.sv
// rtl/linear_layer_srl_fifo_shiftreg.sv - unreset shift-register storage with addressed read
// Kept free of reset so the array maps onto SRL primitives.
module linear_layer_srl_fifo_shiftreg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_srl[i] <= r_srl[i-1];
      end
      r_srl[0] <= i_din;
    end
  end

  assign o_dout = r_srl[i_addr];

endmodule

// File: rtl/linear_layer_srl_fifo.sv
// rtl/linear_layer_srl_fifo.sv - SRL FIFO with occupancy, almost flags, sticky errors, optional output register
module linear_layer_srl_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int OUT_REG       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(DEPTH + OUT_REG);
  localparam logic [CNT_W-1:0] AFULL_T  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_T = CNT_W'(AEMPTY_THRESH);

  if (!srl_params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH, OUT_REG)) begin : g_param_check
    $error("linear_layer_srl_fifo: illegal DATA_WIDTH/ADDR_WIDTH/DEPTH/OUT_REG combination");
  end

  logic [CNT_W-1:0]      r_srl_cnt;
  logic [CNT_W-1:0]      w_srl_cnt_next;
  logic [CNT_W-1:0]      w_occ;
  logic [CNT_W-1:0]      w_occ_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_out_valid;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_srl_dout;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  assign w_push    = if_write_ce & if_write & if_full_n;
  assign w_pop     = if_read_ce & if_read & if_empty_n;
  assign w_rd_addr = ADDR_WIDTH'(r_srl_cnt - CNT_W'(1));

  linear_layer_srl_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shiftreg (
    .clk    (clk),
    .i_we   (w_push),
    .i_din  (if_din),
    .i_addr (w_rd_addr),
    .o_dout (w_srl_dout)
  );

  // w_load is whatever removes a word from the SRL: a pop directly, or a refill of the output stage.
  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    assign w_load = (r_srl_cnt != '0) && (!r_out_valid || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_srl_dout;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end

    assign w_out_valid = r_out_valid;
    assign w_dout      = r_out_data;
    assign w_occ       = r_srl_cnt + CNT_W'(r_out_valid);
  end else begin : g_no_out_reg
    assign w_load      = w_pop;
    assign w_out_valid = (r_srl_cnt != '0);
    assign w_dout      = w_srl_dout;
    assign w_occ       = r_srl_cnt;
  end

  assign w_srl_cnt_next = r_srl_cnt + CNT_W'(w_push) - CNT_W'(w_load);
  assign w_occ_next     = w_occ + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_srl_cnt      <= '0;
      r_almost_full  <= (AFULL_THRESH == 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_srl_cnt      <= w_srl_cnt_next;
      r_almost_full  <= (w_occ_next >= AFULL_T);
      r_almost_empty <= (w_occ_next <= AEMPTY_T);
      if (if_write_ce && if_write && !if_full_n) r_overflow  <= 1'b1;
      if (if_read_ce && if_read && !if_empty_n)  r_underflow <= 1'b1;
    end
  end

  assign if_full_n         = (w_occ != CAPACITY);
  assign if_empty_n        = w_out_valid;
  assign if_dout           = w_dout;
  assign if_num_data_valid = w_occ;
  assign if_almost_full    = r_almost_full;
  assign if_almost_empty   = r_almost_empty;
  assign overflow_err      = r_overflow;
  assign underflow_err     = r_underflow;

endmodule

// File: tb/tb_linear_layer_srl_fifo.sv
// tb/tb_linear_layer_srl_fifo.sv - randomized and directed checks of both FIFO configurations against a queue model
module tb_linear_layer_srl_fifo;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // A: DEPTH=16, combinational output. B: DEPTH=4, registered output (capacity 5).
  logic        a_wce, a_w, a_rce, a_r, a_full_n, a_empty_n, a_af, a_ae, a_ovf, a_unf;
  logic [31:0] a_din, a_dout;
  logic [4:0]  a_cnt;
  logic        b_wce, b_w, b_rce, b_r, b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_unf;
  logic [31:0] b_din, b_dout;
  logic [2:0]  b_cnt;

  linear_layer_srl_fifo #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(1), .OUT_REG(0)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_write_ce(a_wce), .if_write(a_w), .if_din(a_din), .if_full_n(a_full_n),
    .if_read_ce(a_rce), .if_read(a_r), .if_dout(a_dout), .if_empty_n(a_empty_n),
    .if_num_data_valid(a_cnt), .if_almost_full(a_af), .if_almost_empty(a_ae),
    .overflow_err(a_ovf), .underflow_err(a_unf)
  );

  linear_layer_srl_fifo #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .OUT_REG(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_write_ce(b_wce), .if_write(b_w), .if_din(b_din), .if_full_n(b_full_n),
    .if_read_ce(b_rce), .if_read(b_r), .if_dout(b_dout), .if_empty_n(b_empty_n),
    .if_num_data_valid(b_cnt), .if_almost_full(b_af), .if_almost_empty(b_ae),
    .overflow_err(b_ovf), .underflow_err(b_unf)
  );

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          vb;
  bit          ovf_a, unf_a, ovf_b, unf_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_a_state(input string tag);
    chk({tag, "_a_empty_n"}, a_empty_n, qa.size() > 0);
    chk({tag, "_a_full_n"}, a_full_n, qa.size() < 16);
    chk({tag, "_a_cnt"}, a_cnt, qa.size());
    chk({tag, "_a_afull"}, a_af, qa.size() >= 14);
    chk({tag, "_a_aempty"}, a_ae, qa.size() <= 1);
    chk({tag, "_a_ovf"}, a_ovf, ovf_a);
    chk({tag, "_a_unf"}, a_unf, unf_a);
    if (qa.size() > 0) chk({tag, "_a_dout"}, a_dout, qa[0]);
  endtask

  task automatic check_b_state(input string tag);
    chk({tag, "_b_empty_n"}, b_empty_n, vb);
    chk({tag, "_b_full_n"}, b_full_n, qb.size() < 5);
    chk({tag, "_b_cnt"}, b_cnt, qb.size());
    chk({tag, "_b_afull"}, b_af, qb.size() >= 3);
    chk({tag, "_b_aempty"}, b_ae, qb.size() <= 1);
    chk({tag, "_b_ovf"}, b_ovf, ovf_b);
    chk({tag, "_b_unf"}, b_unf, unf_b);
    if (vb) chk({tag, "_b_dout"}, b_dout, qb[0]);
  endtask

  task automatic set_a(input bit wce, input bit w, input bit rce, input bit r, input logic [31:0] d);
    a_wce = wce; a_w = w; a_rce = rce; a_r = r; a_din = d;
  endtask

  task automatic set_b(input bit wce, input bit w, input bit rce, input bit r, input logic [31:0] d);
    b_wce = wce; b_w = w; b_rce = rce; b_r = r; b_din = d;
  endtask

  task automatic idle();
    set_a(0, 0, 0, 0, 32'h0);
    set_b(0, 0, 0, 0, 32'h0);
  endtask

  // Called at a falling edge with inputs already driven; advances one clock and checks both FIFOs.
  // Model B: a word must spend an edge in the SRL before it can enter the output slot.
  task automatic cycle();
    bit pa, ra, pb, rb, vb_n;
    int srlb;
    pa = a_wce && a_w && (qa.size() < 16);
    ra = a_rce && a_r && (qa.size() > 0);
    if (a_wce && a_w && qa.size() == 16) ovf_a = 1;
    if (a_rce && a_r && qa.size() == 0)  unf_a = 1;
    pb = b_wce && b_w && (qb.size() < 5);
    rb = b_rce && b_r && vb;
    if (b_wce && b_w && qb.size() == 5) ovf_b = 1;
    if (b_rce && b_r && !vb)            unf_b = 1;
    srlb = qb.size() - int'(vb);
    @(posedge clk);
    if (ra) void'(qa.pop_front());
    if (pa) qa.push_back(a_din);
    vb_n = (srlb > 0) || (vb && !rb);
    if (rb) void'(qb.pop_front());
    if (pb) qb.push_back(b_din);
    vb = vb_n;
    @(negedge clk);
    check_a_state("cyc");
    check_b_state("cyc");
  endtask

  // Asynchronous reset taken between edges; requests are held active during reset and must be ignored.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    vb = 0; ovf_a = 0; unf_a = 0; ovf_b = 0; unf_b = 0;
    check_a_state("rst");
    check_b_state("rst");
    set_a(1, 1, 1, 1, 32'h1234_5678);
    set_b(1, 1, 1, 1, 32'h8765_4321);
    @(posedge clk);
    #1;
    chk("rst_hold_a_cnt", a_cnt, 0);
    chk("rst_hold_b_cnt", b_cnt, 0);
    chk("rst_hold_a_empty_n", a_empty_n, 0);
    chk("rst_hold_b_unf", b_unf, 0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      int wp;
      wp = (((k / 100) % 2) == 0) ? 75 : 30;
      set_a($urandom_range(0, 9) != 0, $urandom_range(0, 99) < wp,
            $urandom_range(0, 9) != 0, $urandom_range(0, 99) < (100 - wp), $urandom);
      set_b($urandom_range(0, 9) != 0, $urandom_range(0, 99) < wp,
            $urandom_range(0, 9) != 0, $urandom_range(0, 99) < (100 - wp), $urandom);
      cycle();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    idle();
    @(negedge clk);
    apply_reset();

    // single push, combinational output
    set_a(1, 1, 0, 0, 32'hA5A5_A5A5);
    cycle();
    chk("t1_empty_n", a_empty_n, 1);
    chk("t1_dout", a_dout, 32'hA5A5_A5A5);
    chk("t1_cnt", a_cnt, 1);
    chk("t1_aempty", a_ae, 1);
    set_a(0, 0, 1, 1, 0);
    cycle();
    chk("t1_drained", a_empty_n, 0);

    // fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      set_a(1, 1, 0, 0, i);
      cycle();
      chk("t2_full_n", a_full_n, (i == 15) ? 1'b0 : 1'b1);
      chk("t2_afull", a_af, (i + 1) >= 14);
    end
    set_a(1, 1, 0, 0, 32'hDEAD);
    cycle();
    chk("t2_ovf", a_ovf, 1);
    chk("t2_cnt_full", a_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_data", a_dout, i);
      set_a(0, 0, 1, 1, 0);
      cycle();
    end
    chk("t2_empty", a_empty_n, 0);

    // simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) begin
      set_a(1, 1, 0, 0, 200 + i);
      cycle();
    end
    for (int k = 0; k < 20; k++) begin
      set_a(1, 1, 1, 1, 300 + k);
      chk("t3_dout", a_dout, (k < 5) ? (200 + k) : (300 + k - 5));
      cycle();
      chk("t3_cnt", a_cnt, 5);
    end
    for (int k = 0; k < 5; k++) begin
      chk("t3_tail", a_dout, 315 + k);
      set_a(0, 0, 1, 1, 0);
      cycle();
    end

    // read while empty
    set_a(0, 0, 1, 1, 0);
    cycle();
    chk("t4_unf", a_unf, 1);
    chk("t4_cnt", a_cnt, 0);
    idle();
    for (int k = 0; k < 3; k++) cycle();
    chk("t4_unf_sticky", a_unf, 1);

    // registered output: latency, capacity 5, streaming pops
    set_b(1, 1, 0, 0, 100);
    cycle();
    chk("t5_empty_first_edge", b_empty_n, 0);
    for (int i = 1; i < 6; i++) begin
      set_b(1, 1, 0, 0, 100 + i);
      cycle();
      if (i == 1) begin
        chk("t5_first_valid", b_empty_n, 1);
        chk("t5_first_data", b_dout, 100);
      end
    end
    chk("t5_cnt", b_cnt, 5);
    chk("t5_full_n", b_full_n, 0);
    chk("t5_ovf", b_ovf, 1);
    for (int k = 0; k < 5; k++) begin
      set_b(0, 0, 1, 1, 0);
      chk("t5_stream_valid", b_empty_n, 1);
      chk("t5_stream_data", b_dout, 100 + k);
      cycle();
    end
    chk("t5_empty", b_empty_n, 0);
    chk("t5_cnt_zero", b_cnt, 0);
    idle();

    random_cycles(400);

    // async reset mid-operation with count 9
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      set_a(1, 1, 0, 0, $urandom);
      cycle();
    end
    chk("t7_cnt9", a_cnt, 9);
    idle();
    apply_reset();
    chk("t7_after_cnt", a_cnt, 0);
    chk("t7_after_full_n", a_full_n, 1);
    chk("t7_after_aempty", a_ae, 1);
    random_cycles(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_layer_srl_fifo.md
# linear_layer_srl_fifo

Parametrised shift-register (SRL) FIFO with occupancy tracking, almost-full/almost-empty flags, sticky error flags and an optional registered output stage. It is the general successor to the per-edge start/stream FIFOs between Linear_Layer dataflow processes (PE arrays, pack/unpack stages). It targets SRL inference for shallow, wide channels and exposes the HLS `if_*` handshake so generated wrappers can instantiate it directly.

## Interface
- `DATA_WIDTH`, 32: payload width.
- `ADDR_WIDTH`, 4: SRL address width; DEPTH ≤ 2^ADDR_WIDTH.
- `DEPTH`, 16: SRL entries, ≥ 2.
- `AFULL_THRESH`, DEPTH-2: `if_almost_full` asserts when occupancy ≥ this value.
- `AEMPTY_THRESH`, 1: `if_almost_empty` asserts when occupancy ≤ this value.
- `OUT_REG`, 0: 1 adds a registered output stage; total capacity becomes DEPTH+1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_write_ce` in 1: write clock-enable.
- `if_write` in 1: write request.
- `if_din` in DATA_WIDTH: write data.
- `if_full_n` out 1: space available.
- `if_read_ce` in 1: read clock-enable.
- `if_read` in 1: read request.
- `if_dout` out DATA_WIDTH: head-of-queue data, valid while `if_empty_n`=1.
- `if_empty_n` out 1: data available.
- `if_num_data_valid` out ADDR_WIDTH+1: total occupancy, including the output register.
- `if_almost_full` out 1: registered almost-full flag.
- `if_almost_empty` out 1: registered almost-empty flag.
- `overflow_err` out 1: sticky; set by a rejected write.
- `underflow_err` out 1: sticky; set by a rejected read.

## Operation
- Handshake signals:
  - push = `if_write_ce & if_write & if_full_n`.
  - pop = `if_read_ce & if_read & if_empty_n`.
  - Requests with the enable low are ignored silently.
- SRL storage:
  - On a SRL write, all entries shift up by one and entry 0 takes `if_din`.
  - Read pointer `rd_addr` = SRL count − 1. The head is `SRL[rd_addr]`.
- OUT_REG=0:
  - push only: count +1.
  - pop only: count −1.
  - push and pop together: count unchanged; shift occurs and `rd_addr` is unchanged.
  - `if_dout` is combinational from the SRL.
- OUT_REG=1:
  - The output register loads the SRL head whenever the register is empty or being popped, and SRL count > 0. That load decrements the SRL count.
  - `if_empty_n` = output register valid.
  - `if_dout` is the register, never combinational.
- Flags:
  - `if_full_n` = 0 iff total occupancy = capacity.
  - A write with enable high while full: data dropped, `overflow_err` set.
  - A read with enable high while empty: `underflow_err` set.
  - Error flags clear only on reset.
- Almost flags are computed from next-state occupancy and registered, so they change on the same edge as `if_num_data_valid`.
- Reset values: count 0, `if_full_n`=1, `if_empty_n`=0, `if_almost_empty`=1, `if_almost_full`=0 (1 if AFULL_THRESH=0), errors 0, output register 0 with valid 0. SRL contents are not reset.
- Reset asserted mid-operation discards all contents immediately. No push or pop is accepted while `reset_n`=0.

## Timing
- OUT_REG=0:
  - Push on edge N: `if_empty_n`=1 and data on `if_dout` after edge N.
  - Pop on edge N: next entry visible after edge N.
- OUT_REG=1:
  - Push into an empty FIFO: `if_empty_n` rises after edge N+1.
  - Back-to-back pops sustain 1 word per cycle while the SRL is non-empty.
- `if_full_n` drops after the edge that fills the last slot. It rises after the edge of the first pop from full.
- Push and pop together at full: push rejected, since `if_full_n`=0 that cycle.
- Push and pop together at empty: pop rejected; the push is accepted.
- Throughput: 1 push and 1 pop per cycle sustained.

## Structure
- Shared package `linear_layer_fifo_pkg`: occupancy width function `clog2(DEPTH+OUT_REG+1)` and parameter-legality checks.
- Sub-module `linear_layer_srl_fifo_shiftreg`: SRL array, write enable, address, and combinational read. It has no reset, for SRL inference.
- Top level holds the count, pointer, output register, flags and errors.

## Test plan
- Reset, then one push of 0xA5A5A5A5 (OUT_REG=0): `if_empty_n`=1 the next cycle, `if_dout`=0xA5A5A5A5, `if_num_data_valid`=1, `if_almost_empty`=1.
- Fill 16 words 0..15 with DEPTH=16: `if_full_n`=0 after the 16th edge and `if_almost_full` from count 14. A 17th write sets `overflow_err`; draining yields 0..15 in order.
- With count=5, hold push and pop together for 20 cycles: count stays 5 and output order is preserved with no gaps.
- Read while empty: `underflow_err`=1 and stays 1 until reset; `if_num_data_valid` stays 0.
- OUT_REG=1, DEPTH=4:
  - 5 writes are accepted and a 6th is rejected.
  - The first data appears 2 edges after the first push.
  - Continuous pops run at 1 word per cycle.
- Assert `reset_n` low asynchronously with count=9: all outputs take their reset values before the next edge, and a subsequent push/pop sequence behaves as from fresh reset.
